// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_pkg;

    localparam int unsigned FQ_DATA_WIDTH = 32;
    localparam int unsigned FQ_ADDR_WIDTH = 32;
    localparam int unsigned FQ_PC_STEP    = 4;

    typedef enum logic [1:0] {
        FQ_IDLE,
        FQ_FETCH,
        FQ_HOLD
    } fq_state_t;

    typedef struct packed {
        logic [FQ_DATA_WIDTH-1:0] instr;
        logic [FQ_ADDR_WIDTH-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// In-order DEPTH-entry FIFO of fetched {instr, pc} entries with synchronous flush.
module fq_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fq_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  entry_t                 din,
    input  logic                   pop,
    output entry_t                 dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned PW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch with credit-limited requests and redirect flush.
// Optional same-cycle response bypass when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [ADDR_WIDTH-1:0] instr_pc_plus4
);

    localparam int unsigned           CW      = $clog2(DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(FQ_PC_STEP);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    fq_state_t             state, state_nxt;
    logic [ADDR_WIDTH-1:0] fetch_pc, resp_pc, redirect_base;
    logic [CW-1:0]         outstanding, drop, count;
    logic                  req_fire, resp_keep, push, pop, empty, full, head_valid;
    entry_t                din, head, out_entry;

    assign redirect_base  = redirect_pc & ~ADDR_WIDTH'(3);
    assign imem_req_valid = (state == FQ_FETCH) && !redirect
                            && (({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_keep      = imem_resp_valid && (drop == '0) && !redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FQ_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FQ_IDLE:  if (trigger)  state_nxt = FQ_FETCH;
            FQ_FETCH: if (!trigger) state_nxt = FQ_HOLD;
            FQ_HOLD:  if (trigger)  state_nxt = FQ_FETCH;
            default:  state_nxt = FQ_IDLE;
        endcase
    end

    // On redirect, requests still in flight become the drop budget; a response in the same cycle is already gone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            if (redirect) begin
                fetch_pc <= redirect_base;
                resp_pc  <= redirect_base;
                drop     <= outstanding - CW'(imem_resp_valid);
            end else begin
                if (req_fire)  fetch_pc <= fetch_pc + PC_STEP;
                if (resp_keep) resp_pc  <= resp_pc + PC_STEP;
                if (imem_resp_valid && (drop != '0)) drop <= drop - CW'(1);
            end
        end
    end

    assign din = '{instr: imem_resp_data, pc: resp_pc};

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass     = empty && resp_keep;
    assign head_valid = !empty || bypass;
    assign out_entry  = empty ? din : head;
    assign push       = resp_keep && !(bypass && instr_ready);
`else
    assign head_valid = !empty;
    assign out_entry  = head;
    assign push       = resp_keep;
`endif

    assign pop = !empty && instr_ready;

    fq_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    assign instr_valid    = head_valid;
    assign instr          = head_valid ? out_entry.instr : '0;
    assign instr_pc       = head_valid ? out_entry.pc : '0;
    assign instr_pc_plus4 = head_valid ? (out_entry.pc + PC_STEP) : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: cycle vector table plus multi-cycle redirect/reset sequences.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigger = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    fetch_queue #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .trigger         (trigger),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_pc_plus4  (instr_pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; logic [31:0] p4; } dlv_t;
    typedef struct {
        logic        trig;
        logic        rdy;
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] pc;
    } vec_t;

    mreq_t       pend[$];
    logic [31:0] req_log[$];
    dlv_t        dlv[$];
    int unsigned cyc = 0;
    int unsigned mem_lat = 1;
    logic        mem_quiet = 1'b0;
    logic        mem_flush = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // In-order memory: request seen at cycle c answers at cycle c+mem_lat.
    always begin
        @(posedge clk);
        #2;
        cyc = cyc + 1;
        if (mem_flush) pend.delete();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (!mem_quiet && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend[0].addr);
        end
        @(negedge clk);
        if (imem_resp_valid) void'(pend.pop_front());
        if (rst && imem_req_valid && imem_req_ready) begin
            pend.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
            req_log.push_back(imem_req_addr);
        end
    end

    always @(negedge clk) begin
        if (rst && instr_valid && instr_ready)
            dlv.push_back('{pc: instr_pc, ins: instr, p4: instr_pc_plus4});
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        trigger = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        imem_req_ready = 1'b1;
        mem_flush = 1'b1;
        mem_quiet = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_flush = 1'b0;
        mem_quiet = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_dlv(input int unsigned n, input string name);
        int unsigned k = 0;
        while (dlv.size() < n && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({name, " deliveries"}, 32'(dlv.size() >= n), 32'd1);
    endtask

    task automatic wait_req(input int unsigned n, input string name);
        int unsigned k = 0;
        while (req_log.size() < n && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({name, " requests"}, 32'(req_log.size() >= n), 32'd1);
    endtask

    task automatic check_dlv(input string name, input int unsigned idx, input logic [31:0] pc);
        dlv_t d = '{pc: '0, ins: '0, p4: '0};
        if (idx < dlv.size()) d = dlv[idx];
        check({name, " pc"}, d.pc, pc);
        check({name, " instr"}, d.ins, mem_word(pc));
        check({name, " pc_plus4"}, d.p4, pc + 32'd4);
    endtask

    task automatic check_req(input string name, input int unsigned idx, input logic [31:0] addr);
        logic [31:0] a = 32'hFFFF_FFFF;
        if (idx < req_log.size()) a = req_log[idx];
        check(name, a, addr);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, " req_addr"}, imem_req_addr, 32'h0);
        check({tag, " instr_valid"}, 32'(instr_valid), 32'd0);
        check({tag, " instr"}, instr, 32'h0);
        check({tag, " instr_pc"}, instr_pc, 32'h0);
        check({tag, " instr_pc_plus4"}, instr_pc_plus4, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        vt [20];
        int unsigned br, bd;
        logic [31:0] ex_ins, ex_p4;

        // Latency-1 memory from reset: fill, stall until full, drain, trigger drop/resume.
        vt[0]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 32'd0};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
        vt[3]  = '{1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 32'd12, 1'b1, 32'd4};
        vt[5]  = '{1'b1, 1'b0, 1'b1, 32'd16, 1'b1, 32'd4};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 32'd20, 1'b1, 32'd4};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 32'd20, 1'b1, 32'd4};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 32'd20, 1'b1, 32'd4};
        vt[9]  = '{1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd8};
        vt[10] = '{1'b1, 1'b1, 1'b1, 32'd24, 1'b1, 32'd12};
        vt[11] = '{1'b1, 1'b1, 1'b1, 32'd28, 1'b1, 32'd16};
        vt[12] = '{1'b0, 1'b1, 1'b1, 32'd32, 1'b1, 32'd20};
        vt[13] = '{1'b0, 1'b1, 1'b0, 32'd36, 1'b1, 32'd24};
        vt[14] = '{1'b0, 1'b1, 1'b0, 32'd36, 1'b1, 32'd28};
        vt[15] = '{1'b0, 1'b1, 1'b0, 32'd36, 1'b1, 32'd32};
        vt[16] = '{1'b1, 1'b1, 1'b0, 32'd36, 1'b0, 32'd0};
        vt[17] = '{1'b1, 1'b1, 1'b1, 32'd36, 1'b0, 32'd0};
        vt[18] = '{1'b1, 1'b1, 1'b1, 32'd40, 1'b0, 32'd0};
        vt[19] = '{1'b1, 1'b1, 1'b1, 32'd44, 1'b1, 32'd36};

        #2 rst = 1'b0;
        #1 check_reset_outputs("reset");

        mem_lat = 1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            trigger     = vt[i].trig;
            instr_ready = vt[i].rdy;
            @(negedge clk);
            ex_ins = vt[i].iv ? mem_word(vt[i].pc) : 32'h0;
            ex_p4  = vt[i].iv ? (vt[i].pc + 32'd4) : 32'h0;
            check($sformatf("vec%0d req_valid", i), 32'(imem_req_valid), 32'(vt[i].rv));
            check($sformatf("vec%0d req_addr", i), imem_req_addr, vt[i].addr);
            check($sformatf("vec%0d instr_valid", i), 32'(instr_valid), 32'(vt[i].iv));
            check($sformatf("vec%0d instr_pc", i), instr_pc, vt[i].pc);
            check($sformatf("vec%0d instr", i), instr, ex_ins);
            check($sformatf("vec%0d instr_pc_plus4", i), instr_pc_plus4, ex_p4);
        end

        // Backpressure with latency 3: credit stops at DEPTH requests.
        mem_lat = 3;
        do_reset();
        br = req_log.size();
        bd = dlv.size();
        tick();
        trigger = 1'b1;
        repeat (12) tick();
        @(negedge clk);
        #1;
        check("bp request count", 32'(req_log.size() - br), 32'd4);
        for (int unsigned i = 0; i < 4; i++) check_req($sformatf("bp req%0d", i), br + i, 32'(4 * i));
        check("bp req_valid held low", 32'(imem_req_valid), 32'd0);
        check("bp head valid", 32'(instr_valid), 32'd1);
        check("bp head pc", instr_pc, 32'h0);
        check("bp head instr", instr, mem_word(32'h0));
        tick();
        instr_ready = 1'b1;
        wait_req(br + 5, "bp resume");
        check_req("bp resume addr", br + 4, 32'h10);
        wait_dlv(bd + 8, "bp drain");
        for (int unsigned i = 0; i < 8; i++) check_dlv($sformatf("bp dlv%0d", i), bd + i, 32'(4 * i));

        // Redirect with three requests in flight and an empty queue.
        mem_lat = 5;
        do_reset();
        instr_ready = 1'b1;
        br = req_log.size();
        bd = dlv.size();
        tick(); trigger = 1'b1;
        tick();
        tick();
        tick(); trigger = 1'b0;
        tick(); redirect = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge clk);
        #1;
        check("rd3 in flight", 32'(req_log.size() - br), 32'd3);
        check("rd3 no req in redirect cycle", 32'(imem_req_valid), 32'd0);
        tick(); redirect = 1'b0; trigger = 1'b1;
        @(negedge clk);
        check("rd3 queue empty", 32'(instr_valid), 32'd0);
        wait_req(br + 4, "rd3 restart");
        check_req("rd3 restart addr", br + 3, 32'h100);
        wait_dlv(bd + 3, "rd3");
        check_dlv("rd3 dlv0", bd, 32'h100);
        check_dlv("rd3 dlv1", bd + 1, 32'h104);
        check_dlv("rd3 dlv2", bd + 2, 32'h108);

        // Redirect in the same cycle as a response and a pop.
        mem_lat = 1;
        do_reset();
        instr_ready = 1'b1;
        br = req_log.size();
        bd = dlv.size();
        tick(); trigger = 1'b1;
        repeat (4) tick();
        tick(); redirect = 1'b1; redirect_pc = 32'h0000_0202;
        @(negedge clk);
        check("rdp no req in redirect cycle", 32'(imem_req_valid), 32'd0);
        check("rdp pop valid", 32'(instr_valid), 32'd1);
        check("rdp pop pc", instr_pc, 32'h8);
        check("rdp resp present", 32'(imem_resp_valid), 32'd1);
        tick(); redirect = 1'b0;
        @(negedge clk);
        check("rdp flushed", 32'(instr_valid), 32'd0);
        check("rdp restart valid", 32'(imem_req_valid), 32'd1);
        check("rdp restart addr", imem_req_addr, 32'h200);
        wait_dlv(bd + 5, "rdp");
        check_dlv("rdp dlv0", bd, 32'h0);
        check_dlv("rdp dlv1", bd + 1, 32'h4);
        check_dlv("rdp dlv2", bd + 2, 32'h8);
        check_dlv("rdp dlv3", bd + 3, 32'h200);
        check_dlv("rdp dlv4", bd + 4, 32'h204);
        check_req("rdp req3", br + 3, 32'hC);
        check_req("rdp req4", br + 4, 32'h200);

        // Asynchronous reset with two requests outstanding.
        mem_lat = 3;
        do_reset();
        instr_ready = 1'b1;
        br = req_log.size();
        tick(); trigger = 1'b1;
        tick();
        tick();
        @(negedge clk);
        #1;
        check("arst outstanding", 32'(req_log.size() - br), 32'd2);
        @(posedge clk);
        #3;
        rst = 1'b0;
        trigger = 1'b0;
        mem_flush = 1'b1;
        mem_quiet = 1'b1;
        #1 check_reset_outputs("arst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_flush = 1'b0;
        mem_quiet = 1'b0;
        @(negedge clk);
        check("arst idle after release", 32'(instr_valid), 32'd0);
        br = req_log.size();
        bd = dlv.size();
        tick(); trigger = 1'b1;
        wait_req(br + 1, "arst restart");
        check_req("arst restart addr", br, 32'h0);
        wait_dlv(bd + 3, "arst");
        check_dlv("arst dlv0", bd, 32'h0);
        check_dlv("arst dlv1", bd + 1, 32'h4);
        check_dlv("arst dlv2", bd + 2, 32'h8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
